drive_arbiter: RTL and testbench

Motion controller that sits downstream of the obstacle detector. It arbitrates between operator drive commands and autonomous obstacle avoidance, and issues one motion command per cycle to the motor stage. It takes the detector's per-side obstacle flags (front/left/right/back), debounces them, and sequences stop/turn/reverse manoeuvres when the active direction is blocked.

---
 rtl/car_pkg.sv | 39 +++
 rtl/obs_debounce.sv | 28 ++
 rtl/drive_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_drive_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/car_pkg.sv
// Shared motion codes, controller state encodings and the obstacle side-check helper
// used by the drive arbiter and its testbench.
package car_pkg;

    localparam logic [2:0] MOT_STOP  = 3'd0;
    localparam logic [2:0] MOT_FWD   = 3'd1;
    localparam logic [2:0] MOT_BACK  = 3'd2;
    localparam logic [2:0] MOT_LEFT  = 3'd3;
    localparam logic [2:0] MOT_RIGHT = 3'd4;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_DRIVE      = 3'd1;
    localparam logic [2:0] ST_AVOID_STOP = 3'd2;
    localparam logic [2:0] ST_AVOID_TURN = 3'd3;
    localparam logic [2:0] ST_AVOID_REV  = 3'd4;
    localparam logic [2:0] ST_BLOCKED    = 3'd5;

    typedef struct packed {
        logic f;
        logic l;
        logic r;
        logic b;
    } obs_t;

    // True when the side that the given motion moves towards is obstructed.
    function automatic logic side_blocked(input logic [2:0] mot, input obs_t flags);
        logic blk;
        blk = 1'b0;
        case (mot)
            MOT_FWD:   blk = flags.f;
            MOT_BACK:  blk = flags.b;
            MOT_LEFT:  blk = flags.l;
            MOT_RIGHT: blk = flags.r;
            default:   blk = 1'b0;
        endcase
        return blk;
    endfunction

endpackage

// File: rtl/obs_debounce.sv
// Single-flag debouncer: the output follows the input only after DEB_CYC
// consecutive samples that differ from the current output.
module obs_debounce #(
    parameter int DEB_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= 1'b0;
            cnt  <= 8'd0;
        end else if (din == dout) begin
            cnt <= 8'd0;
        end else if (cnt == 8'(DEB_CYC - 1)) begin
            dout <= din;
            cnt  <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/drive_arbiter.sv
// Motion arbiter: passes operator drive commands to the motor stage and runs
// stop/turn/reverse avoidance when the forward path becomes obstructed.
//
// state      | meaning
// IDLE       | motion STOP, waiting for an operator command
// DRIVE      | executing the accepted operator motion
// AVOID_STOP | STOP hold before choosing an escape manoeuvre
// AVOID_TURN | timed LEFT or RIGHT escape turn
// AVOID_REV  | timed BACK escape reverse
// BLOCKED    | retries exhausted, STOP until the front clears
module drive_arbiter
    import car_pkg::*;
#(
    parameter int DEB_CYC   = 4,
    parameter int STOP_CYC  = 8,
    parameter int TURN_CYC  = 16,
    parameter int REV_CYC   = 12,
    parameter int MAX_RETRY = 3,
    parameter int TW        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       obs_f,
    input  logic       obs_l,
    input  logic       obs_r,
    input  logic       obs_b,
    input  logic       cmd_valid,
    input  logic [2:0] cmd,
    output logic       cmd_ready,
    output logic [2:0] motion,
    output logic [2:0] state,
    output logic       avoid_active,
    output logic [1:0] retry_cnt
);

    localparam logic [TW-1:0] STOP_LD   = TW'(STOP_CYC - 1);
    localparam logic [TW-1:0] TURN_LD   = TW'(TURN_CYC - 1);
    localparam logic [TW-1:0] REV_LD    = TW'(REV_CYC - 1);
    localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

    obs_t           flags;
    logic [TW-1:0]  timer;
    logic [2:0]     state_n;
    logic [2:0]     motion_n;
    logic [TW-1:0]  timer_n;
    logic [1:0]     retry_n;
    logic [1:0]     retry_inc;
    logic           bump;
    logic           accept;
    logic           cmd_is_motion;
    logic           tmr_zero;

    obs_debounce #(.DEB_CYC(DEB_CYC)) u_deb_f (.clk(clk), .rst(rst), .din(obs_f), .dout(flags.f));
    obs_debounce #(.DEB_CYC(DEB_CYC)) u_deb_l (.clk(clk), .rst(rst), .din(obs_l), .dout(flags.l));
    obs_debounce #(.DEB_CYC(DEB_CYC)) u_deb_r (.clk(clk), .rst(rst), .din(obs_r), .dout(flags.r));
    obs_debounce #(.DEB_CYC(DEB_CYC)) u_deb_b (.clk(clk), .rst(rst), .din(obs_b), .dout(flags.b));

    assign cmd_ready     = en & ~rst & ((state == ST_IDLE) | (state == ST_DRIVE));
    assign avoid_active  = (state == ST_AVOID_STOP) | (state == ST_AVOID_TURN) |
                           (state == ST_AVOID_REV)  | (state == ST_BLOCKED);
    assign accept        = cmd_valid & cmd_ready;
    assign cmd_is_motion = (cmd != MOT_STOP) && (cmd <= MOT_RIGHT);
    assign tmr_zero      = (timer == '0);
    assign retry_inc     = (retry_cnt == RETRY_MAX) ? retry_cnt : retry_cnt + 2'd1;

    always_comb begin
        state_n  = state;
        motion_n = motion;
        timer_n  = timer;
        retry_n  = retry_cnt;
        bump     = 1'b0;

        case (state)
            ST_IDLE: begin
                motion_n = MOT_STOP;
                if (accept && cmd_is_motion && !side_blocked(cmd, flags)) begin
                    state_n  = ST_DRIVE;
                    motion_n = cmd;
                end
            end
            ST_DRIVE: begin
                // An obstacle on the active side takes precedence over any command.
                if (side_blocked(motion, flags)) begin
                    motion_n = MOT_STOP;
                    if (motion == MOT_FWD) begin
                        state_n = ST_AVOID_STOP;
                        timer_n = STOP_LD;
                        retry_n = 2'd0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else if (accept) begin
                    if (cmd == MOT_STOP) begin
                        state_n  = ST_IDLE;
                        motion_n = MOT_STOP;
                    end else if (cmd_is_motion) begin
                        if (side_blocked(cmd, flags)) begin
                            state_n  = ST_IDLE;
                            motion_n = MOT_STOP;
                        end else begin
                            motion_n = cmd;
                        end
                    end
                end
            end
            ST_AVOID_STOP: begin
                motion_n = MOT_STOP;
                if (tmr_zero) begin
                    if (!flags.l) begin
                        state_n  = ST_AVOID_TURN;
                        motion_n = MOT_LEFT;
                        timer_n  = TURN_LD;
                    end else if (!flags.r) begin
                        state_n  = ST_AVOID_TURN;
                        motion_n = MOT_RIGHT;
                        timer_n  = TURN_LD;
                    end else if (!flags.b) begin
                        state_n  = ST_AVOID_REV;
                        motion_n = MOT_BACK;
                        timer_n  = REV_LD;
                    end else begin
                        state_n = ST_BLOCKED;
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            ST_AVOID_TURN: begin
                if (side_blocked(motion, flags)) begin
                    bump = 1'b1;
                end else if (tmr_zero) begin
                    if (!flags.f) begin
                        state_n  = ST_DRIVE;
                        motion_n = MOT_FWD;
                        retry_n  = 2'd0;
                    end else begin
                        bump = 1'b1;
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            ST_AVOID_REV: begin
                if (flags.b || tmr_zero) begin
                    bump = 1'b1;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            ST_BLOCKED: begin
                motion_n = MOT_STOP;
                if (!flags.f) begin
                    state_n = ST_IDLE;
                    retry_n = 2'd0;
                end
            end
            default: begin
                state_n  = ST_IDLE;
                motion_n = MOT_STOP;
                timer_n  = '0;
                retry_n  = 2'd0;
            end
        endcase

        // A failed attempt returns to the STOP hold unless the retry budget is spent.
        if (bump) begin
            retry_n  = retry_inc;
            motion_n = MOT_STOP;
            timer_n  = STOP_LD;
            state_n  = (retry_inc == RETRY_MAX) ? ST_BLOCKED : ST_AVOID_STOP;
        end

        if (!en) begin
            state_n  = ST_IDLE;
            motion_n = MOT_STOP;
            timer_n  = '0;
            retry_n  = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            motion    <= MOT_STOP;
            timer     <= '0;
            retry_cnt <= 2'd0;
        end else begin
            state     <= state_n;
            motion    <= motion_n;
            timer     <= timer_n;
            retry_cnt <= retry_n;
        end
    end

endmodule

// File: tb/tb_drive_arbiter.sv
// Directed-vector bench for drive_arbiter with hand-computed expectations
// at default parameters (DEB 4, STOP 8, TURN 16, REV 12, 3 retries).
module tb_drive_arbiter;
    import car_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       obs_f, obs_l, obs_r, obs_b;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_ready;
    logic [2:0] motion;
    logic [2:0] state;
    logic       avoid_active;
    logic [1:0] retry_cnt;

    int checks   = 0;
    int failures = 0;

    drive_arbiter dut (
        .clk(clk), .rst(rst), .en(en),
        .obs_f(obs_f), .obs_l(obs_l), .obs_r(obs_r), .obs_b(obs_b),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .motion(motion), .state(state), .avoid_active(avoid_active),
        .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_st(input string tag, input int st, input int mot, input int rty, input int av);
        check({tag, ".state"}, int'(state), st);
        check({tag, ".motion"}, int'(motion), mot);
        check({tag, ".retry"}, int'(retry_cnt), rty);
        check({tag, ".avoid"}, int'(avoid_active), av);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; cmd_valid = 1'b0; cmd = 3'd0;
        obs_f = 1'b0; obs_l = 1'b0; obs_r = 1'b0; obs_b = 1'b0;
        #1;
        check("reset_ready", int'(cmd_ready), 0);
        step(2);
        expect_st("reset", ST_IDLE, MOT_STOP, 0, 0);
        rst = 1'b0;
        #1;
        check("idle_ready", int'(cmd_ready), 1);

        // Operator FWD with clear path
        cmd_valid = 1'b1; cmd = MOT_FWD;
        step(1);
        cmd_valid = 1'b0;
        expect_st("fwd", ST_DRIVE, MOT_FWD, 0, 0);
        check("drive_ready", int'(cmd_ready), 1);

        // Short front glitch is filtered
        obs_f = 1'b1; step(3); obs_f = 1'b0; step(6);
        check("glitch.state", int'(state), ST_DRIVE);
        check("glitch.motion", int'(motion), MOT_FWD);

        // Front obstacle, left turn, front cleared during the STOP hold
        obs_f = 1'b1; step(4);
        check("deb_lat.state", int'(state), ST_DRIVE);
        step(1);
        expect_st("astop", ST_AVOID_STOP, MOT_STOP, 0, 1);
        obs_f = 1'b0;
        step(7);
        check("astop_end", int'(state), ST_AVOID_STOP);
        step(1);
        expect_st("turn_l", ST_AVOID_TURN, MOT_LEFT, 0, 1);
        step(15);
        check("turn_l_end", int'(state), ST_AVOID_TURN);
        step(1);
        expect_st("resume", ST_DRIVE, MOT_FWD, 0, 0);

        // Left becomes blocked mid-turn, then the right turn follows
        obs_f = 1'b1; step(5);
        check("astop2", int'(state), ST_AVOID_STOP);
        step(8);
        expect_st("turn_l2", ST_AVOID_TURN, MOT_LEFT, 0, 1);
        obs_l = 1'b1; step(4);
        check("turn_l2_hold", int'(state), ST_AVOID_TURN);
        step(1);
        expect_st("midturn", ST_AVOID_STOP, MOT_STOP, 1, 1);
        step(8);
        expect_st("turn_r", ST_AVOID_TURN, MOT_RIGHT, 1, 1);

        // Disable mid-turn
        en = 1'b0;
        #1;
        check("dis_ready", int'(cmd_ready), 0);
        step(1);
        expect_st("disable", ST_IDLE, MOT_STOP, 0, 0);
        en = 1'b1; obs_l = 1'b0; obs_f = 1'b0;
        cmd_valid = 1'b1; cmd = 3'd5;
        step(1);
        check("cmd5.state", int'(state), ST_IDLE);
        check("cmd5.motion", int'(motion), MOT_STOP);
        // Debounced front still set, so FWD is dropped
        cmd = MOT_FWD;
        step(1);
        check("blocked_cmd", int'(state), ST_IDLE);
        cmd_valid = 1'b0;
        step(5);

        // BACK drive aborted by rear obstacle; then STOP command from DRIVE
        cmd_valid = 1'b1; cmd = MOT_BACK; step(1); cmd_valid = 1'b0;
        check("back.motion", int'(motion), MOT_BACK);
        obs_b = 1'b1; step(5);
        expect_st("back_obs", ST_IDLE, MOT_STOP, 0, 0);
        obs_b = 1'b0; step(5);
        cmd_valid = 1'b1; cmd = MOT_RIGHT; step(1);
        check("right.motion", int'(motion), MOT_RIGHT);
        cmd = MOT_STOP; step(1); cmd_valid = 1'b0;
        check("cmd_stop", int'(state), ST_IDLE);

        // Front, left and right blocked: reverses until BLOCKED
        cmd_valid = 1'b1; cmd = MOT_FWD; step(1); cmd_valid = 1'b0;
        obs_f = 1'b1; step(5);
        check("rev.astop", int'(state), ST_AVOID_STOP);
        obs_l = 1'b1; obs_r = 1'b1;
        step(8);
        expect_st("rev1", ST_AVOID_REV, MOT_BACK, 0, 1);
        step(11);
        check("rev1_hold", int'(state), ST_AVOID_REV);
        step(1);
        expect_st("rev1_end", ST_AVOID_STOP, MOT_STOP, 1, 1);
        step(8);
        check("rev2", int'(state), ST_AVOID_REV);
        step(12);
        check("rev2_end.retry", int'(retry_cnt), 2);
        step(8);
        check("rev3", int'(state), ST_AVOID_REV);
        step(12);
        expect_st("blocked", ST_BLOCKED, MOT_STOP, 3, 1);
        obs_f = 1'b0; obs_l = 1'b0; obs_r = 1'b0;
        step(4);
        check("blocked_hold", int'(state), ST_BLOCKED);
        step(1);
        expect_st("unblock", ST_IDLE, MOT_STOP, 0, 0);

        // Reset mid-manoeuvre
        cmd_valid = 1'b1; cmd = MOT_FWD; step(1); cmd_valid = 1'b0;
        obs_f = 1'b1; step(5);
        check("rst.astop", int'(state), ST_AVOID_STOP);
        rst = 1'b1; step(1);
        expect_st("rst_mid", ST_IDLE, MOT_STOP, 0, 0);
        rst = 1'b0; obs_f = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
